// File: rtl/gate_bist_pkg.sv
// Shared definitions for the gate-bank BIST controller: FSM states, output
// bit positions and the golden response of a fault-free bank.
package gate_bist_pkg;

  localparam int OUT_W = 7;

  localparam int AND_IDX  = 0;
  localparam int OR_IDX   = 1;
  localparam int NOT_IDX  = 2;
  localparam int NAND_IDX = 3;
  localparam int NOR_IDX  = 4;
  localparam int XOR_IDX  = 5;
  localparam int XNOR_IDX = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_e;

  // Indexed by vec = {a,b}; entry 0 is the a=0,b=0 response.
  localparam logic [3:0][OUT_W-1:0] GOLDEN = {7'h43, 7'h2A, 7'h2E, 7'h5C};

  function automatic logic [OUT_W-1:0] golden_lookup(input logic [1:0] vec);
    return GOLDEN[vec];
  endfunction

endpackage

// File: rtl/gate_expect_lut.sv
// Expected gate-bank response for a given {a,b} input vector.
module gate_expect_lut
  import gate_bist_pkg::*;
(
  input  logic [1:0]       vec_i,
  output logic [OUT_W-1:0] expected_o
);

  assign expected_o = golden_lookup(vec_i);

endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST initiator: walks all four {a,b} vectors LOOPS times, waits SETTLE_CYCLES
// per vector, compares the gate bank outputs to golden and reports the result.
module gate_bist_ctrl
  import gate_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int LOOPS         = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             dut_a,
  output logic             dut_b,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [OUT_W-1:0] fail_vec,
  output logic             fail_valid,
  output logic [1:0]       fail_idx
);

  localparam int SW = $clog2(SETTLE_CYCLES) + 1;
  localparam int LW = $clog2(LOOPS) + 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [LW-1:0] LOOP_LAST   = LW'(LOOPS - 1);

  state_e           state_q;
  logic [1:0]       vec_q;
  logic [LW-1:0]    loop_q;
  logic [SW-1:0]    settle_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [OUT_W-1:0] fail_vec_q;
  logic             fail_valid_q;
  logic [1:0]       fail_idx_q;

  logic [OUT_W-1:0] expected_d;
  logic [OUT_W-1:0] mismatch_d;
  logic [OUT_W-1:0] fail_vec_d;

  gate_expect_lut u_lut (
    .vec_i      (vec_q),
    .expected_o (expected_d)
  );

  assign mismatch_d = dut_out ^ expected_d;
  assign fail_vec_d = fail_vec_q | mismatch_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      vec_q        <= '0;
      loop_q       <= '0;
      settle_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_vec_q   <= '0;
      fail_valid_q <= 1'b0;
      fail_idx_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q      <= ST_SETTLE;
            vec_q        <= '0;
            loop_q       <= '0;
            settle_q     <= SETTLE_LOAD;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_vec_q   <= '0;
            fail_valid_q <= 1'b0;
            fail_idx_q   <= '0;
          end
        end
        ST_SETTLE: begin
          if (settle_q == '0) begin
            state_q <= ST_CHECK;
          end else begin
            settle_q <= settle_q - SW'(1);
          end
        end
        ST_CHECK: begin
          fail_vec_q <= fail_vec_d;
          if ((mismatch_d != '0) && !fail_valid_q) begin
            fail_valid_q <= 1'b1;
            fail_idx_q   <= vec_q;
          end
          // vec is left at 3 on completion so the bank inputs hold at {1,1}.
          if ((vec_q == 2'd3) && (loop_q == LOOP_LAST)) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (fail_vec_d == '0);
          end else begin
            if (vec_q == 2'd3) begin
              loop_q <= loop_q + LW'(1);
            end
            vec_q    <= vec_q + 2'd1;
            settle_q <= SETTLE_LOAD;
            state_q  <= ST_SETTLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dut_a      = vec_q[1];
  assign dut_b      = vec_q[0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_vec   = fail_vec_q;
  assign fail_valid = fail_valid_q;
  assign fail_idx   = fail_idx_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Randomized self-checking bench for gate_bist_ctrl with a fault-injectable
// behavioural gate bank and a result/timing model derived from gate functions.
module tb_gate_bist_ctrl;

  localparam int NU = 2;
  localparam int S_P [NU] = '{1, 3};
  localparam int L_P [NU] = '{1, 2};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NU-1:0]      start_r;
  logic [NU-1:0][6:0] sa0_m;
  logic [NU-1:0][6:0] sa1_m;
  logic [NU-1:0][6:0] inv_m;

  wire [NU-1:0]      dut_a_w;
  wire [NU-1:0]      dut_b_w;
  wire [NU-1:0]      busy_w;
  wire [NU-1:0]      done_w;
  wire [NU-1:0]      pass_w;
  wire [NU-1:0]      fail_valid_w;
  wire [NU-1:0][6:0] dut_out_w;
  wire [NU-1:0][6:0] fail_vec_w;
  wire [NU-1:0][1:0] fail_idx_w;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Fault-free bank, bit order: and, or, not a, nand, nor, xor, xnor.
  function automatic logic [6:0] gate_ref(input logic a, input logic b);
    return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
  endfunction

  function automatic logic [6:0] bank_model(input logic a, input logic b,
                                            input logic [6:0] sa0, input logic [6:0] sa1,
                                            input logic [6:0] inv);
    return ((gate_ref(a, b) & ~sa0) | sa1) ^ inv;
  endfunction

  generate
    for (genvar gi = 0; gi < NU; gi++) begin : g_dut
      assign dut_out_w[gi] = bank_model(dut_a_w[gi], dut_b_w[gi], sa0_m[gi], sa1_m[gi], inv_m[gi]);

      gate_bist_ctrl #(
        .SETTLE_CYCLES (S_P[gi]),
        .LOOPS         (L_P[gi])
      ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start_r[gi]),
        .dut_a      (dut_a_w[gi]),
        .dut_b      (dut_b_w[gi]),
        .dut_out    (dut_out_w[gi]),
        .busy       (busy_w[gi]),
        .done       (done_w[gi]),
        .pass       (pass_w[gi]),
        .fail_vec   (fail_vec_w[gi]),
        .fail_valid (fail_valid_w[gi]),
        .fail_idx   (fail_idx_w[gi])
      );
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input int u, input string tag);
    chk($sformatf("%s_u%0d_busy", tag, u), 32'(busy_w[u]), 0);
    chk($sformatf("%s_u%0d_done", tag, u), 32'(done_w[u]), 0);
    chk($sformatf("%s_u%0d_pass", tag, u), 32'(pass_w[u]), 0);
    chk($sformatf("%s_u%0d_fvec", tag, u), 32'(fail_vec_w[u]), 0);
    chk($sformatf("%s_u%0d_fvalid", tag, u), 32'(fail_valid_w[u]), 0);
    chk($sformatf("%s_u%0d_fidx", tag, u), 32'(fail_idx_w[u]), 0);
    chk($sformatf("%s_u%0d_ab", tag, u), 32'({dut_a_w[u], dut_b_w[u]}), 0);
  endtask

  // One run on unit u; optionally pokes start while busy or asserts rst at cycle rst_at.
  task automatic run_test(input int u, input bit mid_start, input int rst_at);
    int s;
    int l;
    int n;
    logic [6:0] m;
    logic [6:0] e_fv;
    logic       e_valid;
    logic [1:0] e_idx;
    s = S_P[u];
    l = L_P[u];
    n = 4 * l * (s + 1);
    e_fv = '0;
    e_valid = 1'b0;
    e_idx = '0;
    for (int v = 0; v < 4; v++) begin
      m = bank_model(v[1], v[0], sa0_m[u], sa1_m[u], inv_m[u]) ^ gate_ref(v[1], v[0]);
      e_fv |= m;
      if (m != '0 && !e_valid) begin
        e_valid = 1'b1;
        e_idx = v[1:0];
      end
    end
    @(negedge clk);
    start_r[u] = 1'b1;
    @(negedge clk);
    start_r[u] = 1'b0;
    for (int j = 1; j <= n + 1; j++) begin
      if (j == 1) begin
        chk($sformatf("clr_u%0d_fvec", u), 32'(fail_vec_w[u]), 0);
        chk($sformatf("clr_u%0d_fvalid", u), 32'(fail_valid_w[u]), 0);
        chk($sformatf("clr_u%0d_done", u), 32'(done_w[u]), 0);
      end
      if (j == rst_at) begin
        start_r[u] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_all_zero(u, "midrst");
        $display("run u=%0d rst at cycle %0d", u, j);
        return;
      end
      chk($sformatf("u%0d_c%0d_busy", u, j), 32'(busy_w[u]), 32'(j <= n));
      chk($sformatf("u%0d_c%0d_done", u, j), 32'(done_w[u]), 32'(j > n));
      if (j <= n)
        chk($sformatf("u%0d_c%0d_ab", u, j), 32'({dut_a_w[u], dut_b_w[u]}),
            32'(((j - 1) / (s + 1)) % 4));
      if (mid_start) start_r[u] = (j == 3);
      if (j <= n) @(negedge clk);
    end
    start_r[u] = 1'b0;
    chk($sformatf("u%0d_pass", u), 32'(pass_w[u]), 32'(e_fv == '0));
    chk($sformatf("u%0d_fvec", u), 32'(fail_vec_w[u]), 32'(e_fv));
    chk($sformatf("u%0d_fvalid", u), 32'(fail_valid_w[u]), 32'(e_valid));
    if (e_valid) chk($sformatf("u%0d_fidx", u), 32'(fail_idx_w[u]), 32'(e_idx));
    chk($sformatf("u%0d_hold_ab", u), 32'({dut_a_w[u], dut_b_w[u]}), 3);
    $display("run u=%0d sa0=%02h sa1=%02h inv=%02h exp_fvec=%02h got_fvec=%02h pass=%0b",
             u, sa0_m[u], sa1_m[u], inv_m[u], e_fv, fail_vec_w[u], pass_w[u]);
  endtask

  task automatic set_faults(input int u, input logic [6:0] sa0, input logic [6:0] sa1,
                            input logic [6:0] inv);
    sa0_m[u] = sa0;
    sa1_m[u] = sa1;
    inv_m[u] = inv;
  endtask

  initial begin
    int u;
    int ra;
    start_r = '0;
    sa0_m = '0;
    sa1_m = '0;
    inv_m = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero(0, "reset");
    chk_all_zero(1, "reset");
    rst = 1'b0;

    run_test(0, 1'b0, 0);
    set_faults(0, 7'h01, 7'h00, 7'h00);
    run_test(0, 1'b0, 0);
    set_faults(0, 7'h00, 7'h00, 7'h20);
    run_test(0, 1'b0, 0);
    run_test(0, 1'b0, 0);
    set_faults(0, 7'h00, 7'h00, 7'h00);
    run_test(0, 1'b1, 0);
    run_test(0, 1'b0, 5);
    run_test(0, 1'b0, 0);
    run_test(1, 1'b0, 0);
    run_test(1, 1'b1, 0);

    for (int t = 0; t < 40; t++) begin
      u = int'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0)
        set_faults(u, 7'h00, 7'h00, 7'h00);
      else
        set_faults(u, 7'($urandom & $urandom & $urandom), 7'($urandom & $urandom & $urandom),
                   7'($urandom & $urandom & $urandom));
      ra = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4 * L_P[u] * (S_P[u] + 1))) : 0;
      run_test(u, 1'($urandom_range(0, 1)), ra);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
